// File: rtl/operand_sequencer.sv
// Operand staging for the lab-board ripple adder: debounced LOAD button latches two
// operands in turn, then the adder's sum is captured and held for display.
module operand_sequencer #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switches,
  input  logic             btn_load,
  input  logic             btn_clear,
  input  logic [WIDTH:0]   toplam,
  output logic [WIDTH-1:0] sayi1,
  output logic [WIDTH-1:0] sayi2,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [1:0]       state,
  output logic             load_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SUM  = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  logic             s1, s2;
  logic             db, db_q;
  logic [CNT_W-1:0] cnt;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sayi1_d, sayi2_d;
  logic [WIDTH:0]   result_d;
  logic             result_valid_d;

  // Synchroniser and debouncer; unaffected by btn_clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn_load;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign load_pulse = db & ~db_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_A;
      sayi1        <= '0;
      sayi2        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      sayi1        <= sayi1_d;
      sayi2        <= sayi2_d;
      result       <= result_d;
      result_valid <= result_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sayi1_d        = sayi1;
    sayi2_d        = sayi2;
    result_d       = result;
    result_valid_d = result_valid;

    case (state_q)
      S_A: begin
        if (load_pulse) begin
          sayi1_d = switches;
          state_d = S_B;
        end
      end
      S_B: begin
        if (load_pulse) begin
          sayi2_d = switches;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        result_d       = toplam;
        result_valid_d = 1'b1;
        state_d        = S_SHOW;
      end
      S_SHOW: begin
        if (load_pulse) begin
          sayi1_d        = switches;
          result_valid_d = 1'b0;
          state_d        = S_B;
        end
      end
      default: state_d = S_A;
    endcase

    // Clear overrides any load taken above in the same cycle.
    if (btn_clear) begin
      state_d        = S_A;
      sayi1_d        = '0;
      sayi2_d        = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
    end
  end

  assign state = state_q;

endmodule
